// File: rtl/imem_loader.sv
// Instruction RAM loader: fills a 4096x32 RAM from a byte stream while the
// CPU is held in reset.
//
// Stream: 2-byte little-endian word count N (1..DEPTH), then N words of
// 4 bytes each, little-endian.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start               1-cycle pulse that begins a load (ignored while busy)
//   in_valid, in_data   byte source; transfer = in_valid & in_ready
//   in_ready            loader accepts a byte this cycle
//   mem_we/addr/wdata   RAM write port, one strobe per assembled word
//   cpu_hold            holds the CPU in reset while loading or in error
//   busy                loader is in LEN0, LEN1 or DATA
//   done, err           result of the last load (levels)
//   word_count          words written in the current/last load
module imem_loader #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t          state;
    logic [7:0]      len_lo;
    logic [ADDR_W:0] n_words;
    logic [1:0]      byte_idx;
    logic [23:0]     asm_data;

    logic            xfer;
    logic [15:0]     len_full;
    logic [ADDR_W:0] next_count;

    assign xfer       = in_valid & in_ready;
    assign len_full   = {in_data, len_lo};
    assign next_count = word_count + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len_lo     <= '0;
            n_words    <= '0;
            byte_idx   <= '0;
            asm_data   <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            // Write strobe is a single-cycle pulse.
            mem_we <= 1'b0;

            unique case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= LEN0;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= '0;
                        cpu_hold   <= 1'b1;
                        busy       <= 1'b1;
                        in_ready   <= 1'b1;
                    end
                end

                LEN0: begin
                    if (xfer) begin
                        len_lo <= in_data;
                        state  <= LEN1;
                    end
                end

                LEN1: begin
                    if (xfer) begin
                        if (len_full == 16'd0 ||
                            {1'b0, len_full} > DEPTH_L) begin
                            // Rejected: CPU stays held until a new load.
                            state    <= ERR;
                            err      <= 1'b1;
                            busy     <= 1'b0;
                            in_ready <= 1'b0;
                        end else begin
                            state    <= DATA;
                            n_words  <= len_full[ADDR_W:0];
                            byte_idx <= 2'd0;
                        end
                    end
                end

                DATA: begin
                    if (xfer) begin
                        byte_idx <= byte_idx + 2'd1;
                        unique case (byte_idx)
                            2'd0: asm_data[7:0]   <= in_data;
                            2'd1: asm_data[15:8]  <= in_data;
                            2'd2: asm_data[23:16] <= in_data;
                            2'd3: begin
                                // word_count doubles as the word index.
                                mem_we     <= 1'b1;
                                mem_addr   <= word_count[ADDR_W-1:0];
                                mem_wdata  <= {in_data, asm_data};
                                word_count <= next_count;
                                if (next_count == n_words) begin
                                    state    <= DONE;
                                    done     <= 1'b1;
                                    cpu_hold <= 1'b0;
                                    busy     <= 1'b0;
                                    in_ready <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios with randomized
// data and gaps, checked against a byte-stream reference model.
module tb_imem_loader;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4096;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int stalls = 0;

    // Observed RAM writes, sampled mid-cycle.
    int          wr_addr[$];
    logic [31:0] wr_data[$];

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(int'(mem_addr));
            wr_data.push_back(mem_wdata);
        end
    end

    // Reference model: word k of a stream is bytes 2+4k..5+4k, little-endian.
    function automatic logic [31:0] model_word(input logic [7:0] s[$], input int k);
        return {s[5+4*k], s[4+4*k], s[3+4*k], s[2+4*k]};
    endfunction

    // Present one byte after `gap` idle cycles; returns on the negedge
    // following the accepting posedge with in_valid still high.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
            stalls++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_byte timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int max_gap);
        for (int i = 0; i < s.size(); i++)
            send_byte(s[i], $urandom_range(0, max_gap));
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_writes(input string name, input logic [7:0] s[$], input int n);
        n_vec++;
        if (wr_addr.size() !== n) begin
            n_err++;
            $display("FAIL %s write count: got %0d required %0d", name, wr_addr.size(), n);
        end
        for (int k = 0; k < n && k < wr_addr.size(); k++) begin
            n_vec++;
            if (wr_addr[k] !== k || wr_data[k] !== model_word(s, k)) begin
                n_err++;
                $display("FAIL %s write %0d: got addr %0d data %h required addr %0d data %h",
                         name, k, wr_addr[k], wr_data[k], k, model_word(s, k));
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_vec++;
        if ({in_ready, mem_we, cpu_hold, busy, done, err} !== 6'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || word_count !== '0) begin
            n_err++;
            $display("FAIL %s: got rdy=%b we=%b hold=%b busy=%b done=%b err=%b addr=%h wd=%h wc=%0d required all 0",
                     name, in_ready, mem_we, cpu_hold, busy, done, err,
                     mem_addr, mem_wdata, word_count);
        end
    endtask

    task automatic build_stream(output logic [7:0] s[$], input int n);
        s.delete();
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        for (int i = 0; i < 4 * n; i++)
            s.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        do_reset(2);
        check_idle_outputs("reset");
    endtask

    task automatic test_single_word();
        logic [7:0] s[$];
        s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        n_vec++;
        if (cpu_hold !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single start: got hold=%b busy=%b rdy=%b required 1 1 1",
                     cpu_hold, busy, in_ready);
        end
        send_stream(s, 0);
        n_vec++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || mem_we !== 1'b1 ||
            word_count !== 13'd1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL single done: got done=%b hold=%b we=%b wc=%0d rdy=%b required 1 0 1 1 0",
                     done, cpu_hold, mem_we, word_count, in_ready);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (wr_data.size() != 1 || wr_data[0] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL single data: got %0d writes required 1 of DEADBEEF",
                     wr_data.size());
        end
        check_writes("single", s, 1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] s[$];
        build_stream(s, 3);
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        stalls = 0;
        send_stream(s, 0);
        n_vec++;
        if (stalls !== 0) begin
            n_err++;
            $display("FAIL b2b stall: got %0d stall cycles required 0", stalls);
        end
        n_vec++;
        if (done !== 1'b1 || word_count !== 13'd3) begin
            n_err++;
            $display("FAIL b2b done: got done=%b wc=%0d required 1 3", done, word_count);
        end
        repeat (2) @(negedge clk);
        check_writes("b2b", s, 3);
    endtask

    task automatic test_bad_length();
        logic [7:0] s[$];
        wr_addr.delete();
        wr_data.delete();
        for (int t = 0; t < 2; t++) begin
            if (t == 0) s = '{8'h00, 8'h00};
            else        s = '{8'h01, 8'h10};
            pulse_start();
            n_vec++;
            if (err !== 1'b0) begin
                n_err++;
                $display("FAIL badlen clear %0d: got err=%b required 0", t, err);
            end
            send_stream(s, 1);
            repeat (3) @(negedge clk);
            n_vec++;
            if (err !== 1'b1 || cpu_hold !== 1'b1 || busy !== 1'b0 ||
                done !== 1'b0 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL badlen %0d: got err=%b hold=%b busy=%b done=%b rdy=%b required 1 1 0 0 0",
                         t, err, cpu_hold, busy, done, in_ready);
            end
        end
        n_vec++;
        if (wr_addr.size() !== 0) begin
            n_err++;
            $display("FAIL badlen writes: got %0d required 0", wr_addr.size());
        end
        pulse_start();
        n_vec++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL badlen restart: got err=%b busy=%b required 0 1", err, busy);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] s[$];
        do_reset(1);
        build_stream(s, 2);
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        for (int i = 0; i < 8; i++)
            send_byte(s[i], 0);
        in_valid = 1'b0;
        do_reset(1);
        check_idle_outputs("midrst");
        repeat (3) @(negedge clk);
        check_idle_outputs("midrst hold");
        check_writes("midrst", s, 1);
    endtask

    task automatic test_full_depth();
        logic [7:0] s[$];
        build_stream(s, DEPTH);
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_stream(s, 1);
        n_vec++;
        if (done !== 1'b1 || word_count !== 13'd4096 || cpu_hold !== 1'b0) begin
            n_err++;
            $display("FAIL full done: got done=%b wc=%0d hold=%b required 1 4096 0",
                     done, word_count, cpu_hold);
        end
        repeat (2) @(negedge clk);
        check_writes("full", s, DEPTH);
    endtask

    task automatic test_start_ignored();
        logic [7:0] s[$];
        do_reset(1);
        build_stream(s, 2);
        wr_addr.delete();
        wr_data.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'($urandom);
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL idle ready: got %b required 0", in_ready);
            end
            @(negedge clk);
        end
        // Byte offered together with start must not be taken.
        in_data = 8'hA5;
        pulse_start();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++)
            send_byte(s[i], $urandom_range(0, 1));
        in_valid = 1'b0;
        pulse_start();
        n_vec++;
        if (busy !== 1'b1 || word_count !== 13'd1 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL start ignored: got busy=%b wc=%0d rdy=%b required 1 1 1",
                     busy, word_count, in_ready);
        end
        for (int i = 6; i < 10; i++)
            send_byte(s[i], $urandom_range(0, 1));
        in_valid = 1'b0;
        n_vec++;
        if (done !== 1'b1 || word_count !== 13'd2) begin
            n_err++;
            $display("FAIL start ign done: got done=%b wc=%0d required 1 2", done, word_count);
        end
        repeat (2) @(negedge clk);
        check_writes("startign", s, 2);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_bad_length();
        test_reset_mid_load();
        test_full_depth();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
